// File: rtl/prog_loader.sv
// prog_loader: host-side program loader for the core.
// Takes a byte stream (length byte, then instruction words packed little-endian),
// writes the words into core instruction memory from address 0 upward, then
// raises and holds the core start line. A byte accepted while running starts a reload.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing XOR checksum byte, load_err port).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      stream byte input, in_ready always high
//   imem_we/addr/wdata    instruction memory write port, one strobe per word
//   start                 core start level
//   busy                  high while loading/checking
//   load_err              checksum mismatch flag (macro builds only)
module prog_loader #(
  parameter int unsigned DW  = 8,
  parameter int unsigned IW  = 8,
  parameter int unsigned IMW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic           imem_we,
  output logic [IMW-1:0] imem_addr,
  output logic [IW-1:0]  imem_wdata,
  output logic           start,
  output logic           busy
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic           load_err
`endif
);

  localparam int unsigned BPW = IW / DW;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CW  = IMW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
    ERR,
`endif
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic [CW-1:0]    n_q, n_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic             imem_we_d, start_d, busy_d;
  logic [IMW-1:0]   imem_addr_d;
  logic [IW-1:0]    imem_wdata_d;
  logic [IW-1:0]    word_nxt;
  logic [CW-1:0]    len_n;
  logic             xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0]    csum_q, csum_d;
  logic             load_err_d;
`endif

  assign xfer = in_valid & in_ready;

  // Length byte decode: zero means a full memory image.
  assign len_n = (in_data[IMW-1:0] == '0) ? CW'(1 << IMW) : CW'(in_data[IMW-1:0]);

  // Little-endian word assembly: earlier bytes sit in the low lanes.
  generate
    if (BPW == 1) begin : g_one
      assign word_nxt = in_data;
    end else begin : g_multi
      logic [IW-DW-1:0] sreg;
      logic             ld_byte;
      assign ld_byte  = xfer && (state_q == LOAD);
      assign word_nxt = {in_data, sreg};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sreg <= '0;
        else if (ld_byte) sreg <= word_nxt[IW-1:DW];
      end
    end
  endgenerate

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    n_d          = n_q;
    byte_cnt_d   = byte_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    start_d      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    load_err_d   = load_err;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = LOAD;
          n_d        = len_n;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_cnt_q == BCW'(BPW - 1)) begin
            byte_cnt_d   = '0;
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[IMW-1:0];
            imem_wdata_d = word_nxt;
            word_cnt_d   = word_cnt_q + CW'(1);
            if (word_cnt_q + CW'(1) == n_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = RUN;
`endif
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          if (in_data == csum_q) begin
            state_d = RUN;
          end else begin
            state_d    = ERR;
            load_err_d = 1'b1;
          end
        end
      end
      ERR: begin
        if (xfer) begin
          state_d    = LOAD;
          load_err_d = 1'b0;
          n_d        = len_n;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
`endif
      RUN: begin
        start_d = 1'b1;
        // A byte here is a new length: drop start and reload.
        if (xfer) begin
          start_d    = 1'b0;
          state_d    = LOAD;
          n_d        = len_n;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PROG_LOADER_CHECKSUM_EN
    busy_d = (state_d == LOAD) || (state_d == CHK);
`else
    busy_d = (state_d == LOAD);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      n_q        <= '0;
      byte_cnt_q <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      load_err   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      in_ready   <= 1'b1;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      start      <= start_d;
      busy       <= busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      load_err   <= load_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader (IW=8 and IW=16 instances).
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v8, r8, we8, s8, b8;
  logic [7:0] d8, w8;
  logic [3:0] a8;
  logic       v16, r16, we16, s16, b16;
  logic [7:0] d16;
  logic [15:0] w16;
  logic [3:0] a16;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic       le8, le16;
`endif

  prog_loader #(.DW(8), .IW(8), .IMW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_data(d8), .in_ready(r8),
    .imem_we(we8), .imem_addr(a8), .imem_wdata(w8), .start(s8), .busy(b8)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .load_err(le8)
`endif
  );

  prog_loader #(.DW(8), .IW(16), .IMW(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_data(d16), .in_ready(r16),
    .imem_we(we16), .imem_addr(a16), .imem_wdata(w16), .start(s16), .busy(b16)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .load_err(le16)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       st;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit v, input logic [7:0] d, input logic we, input logic [3:0] addr,
                     input logic [7:0] wd, input logic st, input logic busy);
    vec_t x;
    x.v = v; x.d = d; x.we = we; x.addr = addr; x.wd = wd; x.st = st; x.busy = busy;
    vecs.push_back(x);
  endtask

  // Present one byte (or gap) to the IW=8 instance across one edge; sample #1 after.
  task automatic step8(input bit v, input logic [7:0] d);
    v8 = v; d8 = d;
    @(posedge clk); #1;
    v8 = 1'b0; d8 = '0;
  endtask

  task automatic step16(input bit v, input logic [7:0] d);
    v16 = v; d16 = d;
    @(posedge clk); #1;
    v16 = 1'b0; d16 = '0;
  endtask

  initial begin
    rst_n = 1'b0; v8 = 1'b0; d8 = '0; v16 = 1'b0; d16 = '0;
    #12;
    chk("reset8", {r8, we8, a8, w8, s8, b8}, {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0});
    chk("reset16", {r16, we16, a16, w16, s16, b16}, {1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0});
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("reset_lerr", {le8, le16}, 2'b00);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load of 3 words, then a 1-word reload from RUN.
    add(1, 8'h03, 0, 4'h0, 8'h00, 0, 1);
    add(1, 8'hA1, 1, 4'h0, 8'hA1, 0, 1);
    add(1, 8'hB2, 1, 4'h1, 8'hB2, 0, 1);
    add(1, 8'hC3, 1, 4'h2, 8'hC3, 0, CK);
    if (CK) add(1, 8'hD0, 0, 4'h2, 8'hC3, 0, 0);
    add(0, 8'h00, 0, 4'h2, 8'hC3, 1, 0);
    add(0, 8'h00, 0, 4'h2, 8'hC3, 1, 0);
    add(1, 8'h01, 0, 4'h2, 8'hC3, 0, 1);
    add(1, 8'h55, 1, 4'h0, 8'h55, 0, CK);
    if (CK) add(1, 8'h55, 0, 4'h0, 8'h55, 0, 0);
    add(0, 8'h00, 0, 4'h0, 8'h55, 1, 0);
    add(0, 8'h00, 0, 4'h0, 8'h55, 1, 0);
    foreach (vecs[i]) begin
      step8(vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d", i), {r8, we8, a8, w8, s8, b8},
          {1'b1, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].st, vecs[i].busy});
    end

    // Full-memory load (length 0 = 16 words) with random gaps.
    step8(1, 8'h00);
    chk("full_len", {we8, s8, b8}, 3'b001);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        step8(0, 8'h00);
        chk("full_gap", {we8, s8}, 2'b00);
      end
      step8(1, 8'(i));
      chk($sformatf("full_w%0d", i), {we8, a8, w8}, {1'b1, 4'(i), 8'(i)});
    end
    if (CK) begin
      step8(1, 8'h00);
      chk("full_csum", {we8, s8}, 2'b00);
    end
    for (int k = 0; k < 3; k++) begin
      step8(0, 8'h00);
      chk("full_run", {we8, s8, b8}, 3'b010);
    end

    // Reset mid-load after 2 of 4 words.
    step8(1, 8'h04);
    step8(1, 8'h11);
    step8(1, 8'h22);
    chk("mid_we", {we8, a8}, {1'b1, 4'h1});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset", {r8, we8, a8, w8, s8, b8}, {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_idle", {s8, b8}, 2'b00);
    step8(1, 8'h02);
    chk("rl_len", s8, 1'b0);
    step8(1, 8'h11);
    chk("rl_w0", {we8, a8, w8, s8}, {1'b1, 4'h0, 8'h11, 1'b0});
    step8(1, 8'h22);
    chk("rl_w1", {we8, a8, w8, s8}, {1'b1, 4'h1, 8'h22, 1'b0});
    if (CK) begin
      step8(1, 8'h33);
      chk("rl_csum", s8, 1'b0);
    end
    step8(0, 8'h00);
    chk("rl_start", {we8, s8, b8}, 3'b010);

    // 16-bit words, two bytes each, little-endian.
    step16(1, 8'h02);
    chk("w16_len", {we16, b16}, 2'b01);
    step16(1, 8'h34);
    chk("w16_b0", we16, 1'b0);
    step16(1, 8'h12);
    chk("w16_w0", {we16, a16, w16}, {1'b1, 4'h0, 16'h1234});
    step16(1, 8'h78);
    chk("w16_b2", we16, 1'b0);
    step16(1, 8'h56);
    chk("w16_w1", {we16, a16, w16}, {1'b1, 4'h1, 16'h5678});
    if (CK) begin
      step16(1, 8'h08);
      chk("w16_csum", {we16, s16}, 2'b00);
    end
    step16(0, 8'h00);
    chk("w16_start", {we16, s16, b16}, 3'b010);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum match, mismatch, and recovery.
    step8(1, 8'h02); step8(1, 8'h0F); step8(1, 8'hF0); step8(1, 8'hFF);
    chk("ck_ok", {le8, s8}, 2'b00);
    step8(0, 8'h00);
    chk("ck_ok_run", {le8, s8, b8}, 3'b010);
    step8(1, 8'h02); step8(1, 8'h0F); step8(1, 8'hF0); step8(1, 8'h00);
    chk("ck_bad", {le8, s8, b8}, 3'b100);
    step8(0, 8'h00);
    chk("ck_bad_hold", {le8, s8, b8}, 3'b100);
    step8(1, 8'h01);
    chk("ck_clear", {le8, s8, b8}, 3'b001);
    step8(1, 8'hAA);
    chk("ck_rl_w", {we8, a8, w8}, {1'b1, 4'h0, 8'hAA});
    step8(1, 8'hAA);
    step8(0, 8'h00);
    chk("ck_rl_run", {le8, s8, b8}, 3'b010);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
